// File: rtl/m_memarb_pkg.sv
// Shared definitions for the unified-memory arbiter: default geometry and
// the encoding of the outstanding-read tracker.
package m_memarb_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    S_NONE = 2'd0,
    S_IF   = 2'd1,
    S_DRD  = 2'd2
  } own_t;

endpackage

// File: rtl/m_memarb.sv
// Shares one single-port registered-read memory between instruction fetch and
// data access; data wins collisions, fetch is forced through after STARVE_MAX denials.
//   state  | meaning
//   S_NONE | no read outstanding, no response this cycle
//   S_IF   | fetch read issued last cycle, w_mdout belongs to the fetch port
//   S_DRD  | load issued last cycle, w_mdout belongs to the data port
module m_memarb
  import m_memarb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_ireq,
  input  logic [ADDR_W-1:0] w_iaddr,
  output logic              w_igrant,
  output logic              r_ivalid,
  output logic [DATA_W-1:0] w_idata,
  input  logic              w_dreq,
  input  logic              w_dwe,
  input  logic [ADDR_W-1:0] w_daddr,
  input  logic [DATA_W-1:0] w_dwdata,
  output logic              w_dgrant,
  output logic              r_dvalid,
  output logic [DATA_W-1:0] w_drdata,
  output logic [ADDR_W-1:0] w_maddr,
  output logic              w_mwe,
  output logic [DATA_W-1:0] w_mdin,
  input  logic [DATA_W-1:0] w_mdout
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  own_t          r_own, own_nxt;
  logic [SW-1:0] r_starve, starve_nxt;
  logic          starve_full;

  assign starve_full = (r_starve == SW'(STARVE_MAX));

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_own    <= S_NONE;
      r_starve <= '0;
    end else begin
      r_own    <= own_nxt;
      r_starve <= starve_nxt;
    end
  end

  always_comb begin
    w_igrant   = 1'b0;
    w_dgrant   = 1'b0;
    own_nxt    = S_NONE;
    starve_nxt = r_starve;
    if (!w_rst) begin
      if (w_dreq && w_ireq) begin
        if (starve_full) w_igrant = 1'b1;
        else             w_dgrant = 1'b1;
      end else if (w_dreq) begin
        w_dgrant = 1'b1;
      end else if (w_ireq) begin
        w_igrant = 1'b1;
      end
    end
    // stores produce no response, so they leave the tracker idle
    if (w_igrant)               own_nxt = S_IF;
    else if (w_dgrant && !w_dwe) own_nxt = S_DRD;
    if (!w_ireq || w_igrant)   starve_nxt = '0;
    else if (!starve_full)     starve_nxt = r_starve + SW'(1);
  end

  assign w_maddr  = w_dgrant ? w_daddr : w_iaddr;
  assign w_mwe    = w_dgrant & w_dwe;
  assign w_mdin   = w_dwdata;
  assign r_ivalid = (r_own == S_IF);
  assign r_dvalid = (r_own == S_DRD);
  assign w_idata  = w_mdout;
  assign w_drdata = w_mdout;

endmodule

// File: tb/tb_m_memarb.sv
// Self-checking bench for m_memarb: vector table plus corner sequences, with a
// per-cycle response queue and a shadow memory for expected read data.
module tb_m_memarb;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [11:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [11:0] daddr;
    logic [31:0] dwdata;
    logic        ig;
    logic        dg;
    int          st;
  } vec_t;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ireq, igrant, ivalid, dreq, dwe, dgrant, dvalid, mwe;
  logic [11:0] iaddr, daddr, maddr;
  logic [31:0] idata, dwdata, drdata, mdin, mdout;

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  exp_t        sb_q[$];
  vec_t        tbl[10];
  int          tests = 0;
  int          failed = 0;

  m_memarb dut (
    .w_clk(clk), .w_rst(rst),
    .w_ireq(ireq), .w_iaddr(iaddr), .w_igrant(igrant), .r_ivalid(ivalid), .w_idata(idata),
    .w_dreq(dreq), .w_dwe(dwe), .w_daddr(daddr), .w_dwdata(dwdata),
    .w_dgrant(dgrant), .r_dvalid(dvalid), .w_drdata(drdata),
    .w_maddr(maddr), .w_mwe(mwe), .w_mdin(mdin), .w_mdout(mdout)
  );

  always #5 clk = ~clk;

  // single-port memory: write on edge, registered read
  always @(posedge clk) begin
    if (mwe) mem[maddr] <= mdin;
    mdout <= mem[maddr];
  end

  function automatic vec_t mk(input logic r, input logic ir, input int ia,
                              input logic dr, input logic we, input int da,
                              input logic [31:0] wd, input logic ig, input logic dg,
                              input int st);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = 12'(ia); v.dreq = dr; v.dwe = we;
    v.daddr = 12'(da); v.dwdata = wd; v.ig = ig; v.dg = dg; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; ireq = v.ireq; iaddr = v.iaddr; dreq = v.dreq;
    dwe = v.dwe; daddr = v.daddr; dwdata = v.dwdata;
    #1;
    chk("igrant", 32'(igrant), 32'(v.ig));
    chk("dgrant", 32'(dgrant), 32'(v.dg));
    chk("mwe", 32'(mwe), 32'(v.dg & v.dwe));
    chk("maddr", 32'(maddr), 32'(v.dg ? v.daddr : v.iaddr));
    chk("mdin", mdin, v.dwdata);
    if (v.st >= 0) chk("starve", 32'(dut.r_starve), 32'(v.st));
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      chk("ivalid", 32'(ivalid), 32'(e.iv));
      chk("dvalid", 32'(dvalid), 32'(e.dv));
      if (e.iv) chk("idata", idata, e.data);
      if (e.dv) chk("drdata", drdata, e.data);
    end
    e.iv = 1'b0; e.dv = 1'b0; e.data = '0;
    if (v.ig) begin
      e.iv = 1'b1; e.data = ref_mem[v.iaddr];
    end else if (v.dg && !v.dwe) begin
      e.dv = 1'b1; e.data = ref_mem[v.daddr];
    end
    if (v.dg && v.dwe) ref_mem[v.daddr] = v.dwdata;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'hA000_0000 + 32'(i);
      ref_mem[i] = 32'hA000_0000 + 32'(i);
    end
    mem[5] = 32'h20;   ref_mem[5] = 32'h20;
    mem[7] = 32'h1234; ref_mem[7] = 32'h1234;

    rst = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
    repeat (3) @(posedge clk);

    //          rst ireq ia  dreq dwe da  wdata          ig dg st
    tbl[0] = mk(1, 1, 4,  1, 0, 8,  32'h0,         0, 0, 0);
    tbl[1] = mk(0, 1, 5,  0, 0, 0,  32'h0,         1, 0, 0);
    tbl[2] = mk(0, 1, 6,  1, 0, 7,  32'h0,         0, 1, 0);
    tbl[3] = mk(0, 0, 0,  0, 0, 0,  32'h0,         0, 0, 1);
    tbl[4] = mk(0, 0, 0,  1, 1, 9,  32'hDEADBEEF,  0, 1, 0);
    tbl[5] = mk(0, 0, 0,  1, 0, 9,  32'h0,         0, 1, 0);
    tbl[6] = mk(0, 0, 0,  0, 0, 0,  32'h0,         0, 0, 0);
    tbl[7] = mk(0, 1, 9,  1, 1, 10, 32'h55,        0, 1, 0);
    tbl[8] = mk(0, 1, 9,  0, 0, 0,  32'h0,         1, 0, 1);
    tbl[9] = mk(0, 0, 0,  0, 0, 0,  32'h0,         0, 0, 0);

    e0.iv = 1'b0; e0.dv = 1'b0; e0.data = '0;
    sb_q.push_back(e0);
    for (int i = 0; i < 10; i++) apply(tbl[i]);

    // starvation: continuous loads, fetch forced through every 4th cycle
    for (int k = 0; k < 10; k++)
      apply(mk(0, 1, 3, 1, 0, 20 + k, 32'h0, (k % 4) == 3, (k % 4) != 3, k % 4));
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2));

    // reset mid-stream: pending fetch response still delivered during reset
    apply(mk(0, 1, 5, 0, 0, 0, 32'h0, 1, 0, 0));
    apply(mk(1, 1, 6, 1, 1, 11, 32'hBAD0BAD0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));

    // idle
    for (int k = 0; k < 5; k++) apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    chk("mem11_untouched", mem[11], 32'hA000_000B);
    chk("mem10_store", mem[10], 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/m_memarb.md
# m_memarb

Two-port arbiter that shares one single-port, 4K-word memory (registered read, write on clock edge) between the pipeline's instruction-fetch port and its data-access (load/store) port, so the processor can run from a unified memory. Each cycle it grants the memory to at most one requester, drives the memory address/write controls, and tracks the one outstanding read so the returned word is steered to the right port one cycle later. Data accesses have priority; a starvation counter guarantees forward progress for instruction fetch.

## Interface
Parameters:
- ADDR_W, 12, word-address width (matches 4096-word memory)
- DATA_W, 32, data width
- STARVE_MAX, 3, max consecutive cycles an instruction request may be denied before it is forced through

Ports:
- w_clk  in  1  clock; all state changes on rising edge
- w_rst  in  1  synchronous, active-high reset
- w_ireq  in  1  instruction fetch request (read only)
- w_iaddr  in  ADDR_W  fetch word address
- w_igrant  out  1  fetch accepted this cycle (combinational)
- r_ivalid  out  1  fetch data valid this cycle
- w_idata  out  DATA_W  fetch data (= w_mdout, meaningful only when r_ivalid)
- w_dreq  in  1  data access request
- w_dwe  in  1  1 = store, 0 = load (sampled with w_dreq)
- w_daddr  in  ADDR_W  data word address
- w_dwdata  in  DATA_W  store data
- w_dgrant  out  1  data access accepted this cycle (combinational)
- r_dvalid  out  1  load data valid this cycle (never set for stores)
- w_drdata  out  DATA_W  load data (= w_mdout, meaningful only when r_dvalid)
- w_maddr  out  ADDR_W  memory address
- w_mwe  out  1  memory write enable
- w_mdin  out  DATA_W  memory write data
- w_mdout  in  DATA_W  memory registered read data

## Operation
- Grant decision, combinational from requests, r_starve and w_rst:
  - w_rst=1: no grant.
  - only w_dreq: data granted. Only w_ireq: fetch granted.
  - both: fetch granted if r_starve==STARVE_MAX, else data granted.
  - neither: no grant; w_maddr=w_iaddr, w_mwe=0.
- Memory drive: w_maddr/w_mdin from the granted port; w_mwe = w_dgrant & w_dwe. w_mdin = w_dwdata always.
- Response tracker, 2-bit state r_own: S_NONE, S_IF, S_DRD. Next state = S_IF on fetch grant, S_DRD on data-load grant, S_NONE otherwise (including store grant). r_ivalid = (r_own==S_IF), r_dvalid = (r_own==S_DRD), both registered.
- Starvation counter r_starve (width clog2(STARVE_MAX+1)): increments, saturating at STARVE_MAX, when w_ireq=1 and not granted; clears to 0 when fetch granted or w_ireq=0.
- Requesters hold request/address/data stable until granted; arbiter does not latch requests.
- Store followed by load to same address in next cycle returns the new value (memory write completes at the store's edge).

## Timing
- Reset values: r_ivalid=0, r_dvalid=0, r_own=S_NONE, r_starve=0.
- Read latency: grant in cycle N -> valid high exactly in cycle N+1, data = word at address granted in N.
- Store: committed at the rising edge ending the grant cycle; no response.
- Throughput: one access per cycle; back-to-back grants to either port allowed.
- Fetch worst-case wait with continuous data requests: STARVE_MAX+1 cycles from request to grant.
- Reset mid-operation: reset asserted in cycle N suppresses grants in N; valids are 0 from N+1; any response pending from N-1's grant is still delivered in N, then dropped thereafter; r_starve=0 after the edge.
- w_mwe never asserted while w_rst=1.

## Structure
- Shared package: state encodings S_NONE/S_IF/S_DRD, ADDR_W/DATA_W defaults, STARVE_MAX default.
- Single module; no sub-module. Memory instance lives in the processor top, wired to the w_m* ports.

## Test plan
- Fetch only: w_ireq=1, w_iaddr=5, mem[5]=0x20 -> w_igrant=1 cycle N; r_ivalid=1, w_idata=0x00000020 cycle N+1.
- Collision: both requests, load w_daddr=7 (mem[7]=0x1234) -> w_dgrant=1, w_igrant=0; r_dvalid=1, w_drdata=0x1234 next cycle; r_starve=1.
- Starvation: w_dreq held 1 for 10 cycles with w_ireq=1, STARVE_MAX=3 -> w_igrant first high in 4th cycle; r_starve returns to 0; data resumes next cycle.
- Store then load: store 0xDEADBEEF to addr 9 cycle N, load addr 9 cycle N+1 -> r_dvalid cycle N+2 with 0xDEADBEEF; r_dvalid=0 in N+1.
- Reset mid-stream: fetch granted cycle N, w_rst=1 cycle N+1 with both requests -> no grants, w_mwe=0 in N+1; r_ivalid=1 in N+1 only; all valids 0 in N+2.
- Idle: no requests for 5 cycles -> no grants, w_mwe=0, valids 0, r_starve=0.
